// File: rtl/cast_op_sequencer.sv
// cast_op_sequencer: runs up to four cast ops of one job through a shared
// add-and-shift unit, one op per cycle, on a valid/ready result stream.
module cast_op_sequencer #(
    parameter int unsigned W   = 4,
    parameter int unsigned EXT = W + 2,
    parameter int unsigned SHW = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*W-1:0]   in_ops,
    input  logic [3:0]       in_mask,
    input  logic [SHW-1:0]   in_sh,
    input  logic [EXT-1:0]   in_k,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXT-1:0]   out_data,
    output logic [1:0]       out_tag,
    output logic             out_last,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [W-1:0]     r_s, w_s_nxt;
    logic [W-1:0]     r_u, w_u_nxt;
    logic [3:0]       r_mask, w_mask_nxt;
    logic [SHW-1:0]   r_sh, w_sh_nxt;
    logic [EXT-1:0]   r_k, w_k_nxt;
    logic             r_out_valid, w_out_valid_nxt;
    logic [EXT-1:0]   r_out_data, w_out_data_nxt;
    logic [1:0]       r_out_tag, w_out_tag_nxt;
    logic             r_out_last, w_out_last_nxt;

    logic [1:0]       w_sel;
    logic [3:0]       w_mask_rem;
    logic [W-1:0]     w_t;
    logic [EXT-1:0]   w_ext;
    logic [EXT-1:0]   w_sum;
    logic [EXT-1:0]   w_result;
    logic             w_issue;

    // Lowest set bit of the remaining mask selects the next op.
    always_comb begin
        w_sel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (r_mask[i]) w_sel = 2'(i);
        end
    end

    assign w_mask_rem = r_mask & ~(4'b0001 << w_sel);

    // Shared datapath: extend the selected operand, add k, logical shift right.
    always_comb begin
        w_t = W'($signed(r_s) >>> 1);
        case (w_sel)
            2'd0:    w_ext = EXT'($signed(r_u));
            2'd1:    w_ext = EXT'(r_u);
            2'd2:    w_ext = EXT'(w_t);
            default: w_ext = EXT'($signed(w_t));
        endcase
    end

    assign w_sum    = w_ext + r_k;
    assign w_result = (32'(r_sh) >= EXT) ? '0 : (w_sum >> r_sh);
    assign w_issue  = (r_state == RUN) && (!r_out_valid || out_ready);

    // Next-state, job latch and output-beat logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_s_nxt         = r_s;
        w_u_nxt         = r_u;
        w_mask_nxt      = r_mask;
        w_sh_nxt        = r_sh;
        w_k_nxt         = r_k;
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        w_out_tag_nxt   = r_out_tag;
        w_out_last_nxt  = r_out_last;

        if (r_out_valid && out_ready) w_out_valid_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_s_nxt    = in_ops[2*W-1:W];
                    w_u_nxt    = in_ops[W-1:0];
                    w_mask_nxt = in_mask;
                    w_sh_nxt   = in_sh;
                    w_k_nxt    = in_k;
                    if (in_mask != 4'd0) w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_issue) begin
                    w_out_valid_nxt = 1'b1;
                    w_out_data_nxt  = w_result;
                    w_out_tag_nxt   = w_sel;
                    w_out_last_nxt  = (w_mask_rem == 4'd0);
                    w_mask_nxt      = w_mask_rem;
                    if (w_mask_rem == 4'd0) w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_s         <= '0;
            r_u         <= '0;
            r_mask      <= '0;
            r_sh        <= '0;
            r_k         <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_tag   <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_s         <= w_s_nxt;
            r_u         <= w_u_nxt;
            r_mask      <= w_mask_nxt;
            r_sh        <= w_sh_nxt;
            r_k         <= w_k_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_tag   <= w_out_tag_nxt;
            r_out_last  <= w_out_last_nxt;
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state == RUN);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_tag   = r_out_tag;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_cast_op_sequencer.sv
// Self-checking bench for cast_op_sequencer with an arithmetic reference model.
module tb_cast_op_sequencer;

    localparam int unsigned W   = 4;
    localparam int unsigned EXT = 6;
    localparam int unsigned SHW = 3;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2*W-1:0]   in_ops;
    logic [3:0]       in_mask;
    logic [SHW-1:0]   in_sh;
    logic [EXT-1:0]   in_k;
    logic             out_valid;
    logic             out_ready;
    logic [EXT-1:0]   out_data;
    logic [1:0]       out_tag;
    logic             out_last;
    logic             busy;

    int checks;
    int errors;

    cast_op_sequencer #(.W(W), .EXT(EXT), .SHW(SHW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ops    (in_ops),
        .in_mask   (in_mask),
        .in_sh     (in_sh),
        .in_k      (in_k),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: cast rules expressed on plain integers.
    function automatic int model(input int op, input int s, input int u, input int sh, input int k);
        int sv, us, t, e;
        sv = (s >= 8) ? s - 16 : s;
        us = (u >= 8) ? u - 16 : u;
        t  = (sv < 0) ? -((1 - sv) / 2) : sv / 2;
        case (op)
            0:       e = us;
            1:       e = u;
            2:       e = (t + 16) % 16;
            default: e = t;
        endcase
        e = (((e + k) % 64) + 64) % 64;
        return (sh >= 6) ? 0 : e / (1 << sh);
    endfunction

    // Offer one job, then consume and check every beat against the model.
    // mode 0: always ready, 1: random ready, 2: ready low 3 cycles on first beat.
    task automatic run_job(input int s, input int u, input int mask, input int sh,
                           input int k, input int mode);
        int  qtag[$];
        int  qdat[$];
        int  qlast[$];
        int  cyc, held, pops;
        bit  pv, pr;
        int  pd, pt;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                qtag.push_back(i);
                qdat.push_back(model(i, s, u, sh, k));
                qlast.push_back(0);
            end
        end
        if (qlast.size() > 0) qlast[qlast.size()-1] = 1;

        out_ready = 1'b1;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_wait in_ready=%0b required 1", in_ready);
        end
        in_valid = 1'b1;
        in_ops   = 8'((s << 4) | u);
        in_mask  = 4'(mask);
        in_sh    = 3'(sh);
        in_k     = 6'(k);
        @(negedge clk);
        in_valid = 1'b0;
        in_ops   = 8'($urandom);
        in_mask  = 4'($urandom);
        in_sh    = 3'($urandom);
        in_k     = 6'($urandom);

        cyc = 0; held = 0; pops = 0; pv = 1'b0; pr = 1'b1; pd = 0; pt = 0;
        while (qtag.size() > 0 && cyc < 300) begin
            if (pv && !pr) begin
                checks++;
                if (out_valid !== 1'b1 || int'(out_data) != pd || int'(out_tag) != pt) begin
                    errors++;
                    $display("FAIL hold_stable valid=%0b data=%0d tag=%0d required valid=1 data=%0d tag=%0d",
                             out_valid, out_data, out_tag, pd, pt);
                end
            end
            if (out_valid) begin
                checks++;
                if (int'(out_tag) != qtag[0] || int'(out_data) != qdat[0] || int'(out_last) != qlast[0]) begin
                    errors++;
                    $display("FAIL beat tag=%0d data=%0d last=%0b required tag=%0d data=%0d last=%0d",
                             out_tag, out_data, out_last, qtag[0], qdat[0], qlast[0]);
                end
            end
            if (mode == 1) out_ready = 1'($urandom_range(0, 1));
            else if (mode == 2 && pops == 0 && out_valid && held < 3) begin
                out_ready = 1'b0;
                held++;
            end else out_ready = 1'b1;
            if (out_valid && out_ready) begin
                void'(qtag.pop_front());
                void'(qdat.pop_front());
                void'(qlast.pop_front());
                pops++;
            end
            pv = out_valid; pr = out_ready; pd = int'(out_data); pt = int'(out_tag);
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (qtag.size() != 0) begin
            errors++;
            $display("FAIL beat_timeout remaining=%0d required 0", qtag.size());
        end
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL job_tail valid=%0b in_ready=%0b busy=%0b required 0 1 0",
                     out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_ops = '0; in_mask = '0;
        in_sh = '0; in_k = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 6'd0 || out_tag !== 2'd0 ||
            out_last !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state valid=%0b data=%0d tag=%0d last=%0b busy=%0b in_ready=%0b required 0 0 0 0 0 1",
                     out_valid, out_data, out_tag, out_last, busy, in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_job(0, 8, 4'b0011, 5, 0, 0);
        run_job(8, 0, 4'b1100, 3, 0, 0);
        run_job(0, 0, 4'b0010, 0, 63, 0);
        run_job(0, 7, 4'b0001, 0, 31, 0);
        // Directed values cross-checked against hand-derived constants.
        checks++;
        if (model(0, 0, 8, 5, 0) != 1 || model(3, 8, 0, 3, 0) != 7 || model(0, 0, 7, 0, 31) != 38) begin
            errors++;
            $display("FAIL model_const op0=%0d op3=%0d wrap=%0d required 1 7 38",
                     model(0, 0, 8, 5, 0), model(3, 8, 0, 3, 0), model(0, 0, 7, 0, 31));
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid = 1'b1; in_ops = 8'h80; in_mask = 4'b1100; in_sh = 3'd3; in_k = 6'd0;
        @(negedge clk);
        in_valid = 1'b0; in_ops = 8'hFF; in_mask = 4'hF; in_sh = 3'd0; in_k = 6'd5;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_e0 busy=%0b valid=%0b in_ready=%0b required 1 0 0", busy, out_valid, in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 2'd2 || out_data !== 6'd1 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL b2b_e1 valid=%0b tag=%0d data=%0d last=%0b required 1 2 1 0",
                     out_valid, out_tag, out_data, out_last);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 2'd3 || out_data !== 6'd7 || out_last !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_e2 valid=%0b tag=%0d data=%0d last=%0b in_ready=%0b required 1 3 7 1 1",
                     out_valid, out_tag, out_data, out_last, in_ready);
        end
        in_valid = 1'b1; in_ops = 8'h07; in_mask = 4'b0001; in_sh = 3'd0; in_k = 6'd31;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_e3 valid=%0b busy=%0b required 0 1", out_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 2'd0 || out_data !== 6'b100110 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL b2b_e4 valid=%0b tag=%0d data=%0d last=%0b required 1 0 38 1",
                     out_valid, out_tag, out_data, out_last);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_tail valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        run_job(5, 9, 4'b1111, 1, 17, 2);
        run_job(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 4'b1111, 0,
                int'($urandom_range(0, 63)), 1);
    endtask

    task automatic test_zero_mask_shift();
        run_job(3, 12, 4'b0000, 2, 9, 0);
        run_job(15, 15, 4'b1111, 7, 63, 0);
        run_job(8, 8, 4'b0101, 6, 40, 1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            run_job(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 63)), 1);
        end
    endtask

    task automatic test_reset_mid();
        int seen, cyc;
        out_ready = 1'b1;
        in_valid = 1'b1; in_ops = 8'h3C; in_mask = 4'hF; in_sh = 3'd0; in_k = 6'd1;
        @(negedge clk);
        in_valid = 1'b0;
        seen = 0; cyc = 0;
        while (seen < 2 && cyc < 20) begin
            @(negedge clk);
            if (out_valid) seen++;
            cyc++;
        end
        checks++;
        if (seen != 2) begin
            errors++;
            $display("FAIL midreset_beats seen=%0d required 2", seen);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 6'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_clear valid=%0b busy=%0b data=%0d in_ready=%0b required 0 0 0 1",
                     out_valid, busy, out_data, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_job(6, 10, 4'b0110, 1, 3, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_zero_mask_shift();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
